// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master engine between NUM_REQ requesters.
// Sequences start/done, enforces a chip-select idle gap and aborts hung transfers.

module spi_xfer_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CS_W    = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ*CS_W-1:0]    req_cs_i,
   input  logic [NUM_REQ*DATA_W-1:0]  req_tx_i,
   output logic [NUM_REQ-1:0]         rsp_valid_o,
   output logic [DATA_W-1:0]          rsp_rx_o,
   output logic                       rsp_err_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
   output logic                       busy_o,
   input  logic [7:0]                 cfg_gap_i,
   output logic                       spi_start_o,
   output logic [DATA_W-1:0]          spi_tx_o,
   output logic [CS_W-1:0]            spi_cs_sel_o,
   input  logic                       spi_busy_i,
   input  logic                       spi_done_i,
   input  logic [DATA_W-1:0]          spi_rx_i
);

   localparam int unsigned    IdW    = $clog2(NUM_REQ);
   localparam int unsigned    WdW    = $clog2(TIMEOUT);
   localparam logic [WdW-1:0] WdTerm = WdW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWait,
      StResp,
      StGap
   } state_e;

   state_e              state_q, state_d;
   logic [IdW-1:0]      last_q, last_d;
   logic [IdW-1:0]      grant_q, grant_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [CS_W-1:0]     cs_q, cs_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                err_q, err_d;
   logic [7:0]          gap_q, gap_d;
   logic [WdW-1:0]      wdog_q, wdog_d;

   logic [CS_W-1:0]     cs_arr [NUM_REQ];
   logic [DATA_W-1:0]   tx_arr [NUM_REQ];
   logic                arb_found;
   logic [IdW-1:0]      arb_idx;
   logic [IdW-1:0]      cand;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign cs_arr[k] = req_cs_i[k*CS_W +: CS_W];
      assign tx_arr[k] = req_tx_i[k*DATA_W +: DATA_W];
   end

   // Scan starting just after the last served requester so everyone gets a turn.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IdW'((32'(last_q) + i) % NUM_REQ);
         if (!arb_found && req_valid_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      tx_d        = tx_q;
      cs_d        = cs_q;
      rx_d        = rx_q;
      err_d       = err_q;
      gap_d       = gap_q;
      wdog_d      = wdog_q;
      req_ready_o = '0;
      rsp_valid_o = '0;
      spi_start_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Gated by rst_n so ready stays low while reset is held.
            if (arb_found && rst_n) begin
               req_ready_o[arb_idx] = 1'b1;
               grant_d              = arb_idx;
               tx_d                 = tx_arr[arb_idx];
               cs_d                 = cs_arr[arb_idx];
               state_d              = StStart;
            end
         end
         StStart: begin
            if (!spi_busy_i) begin
               spi_start_o = 1'b1;
               wdog_d      = '0;
               state_d     = StWait;
            end
         end
         StWait: begin
            wdog_d = wdog_q + 1'b1;
            // A done on the terminal count still completes normally.
            if (spi_done_i) begin
               rx_d    = spi_rx_i;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (wdog_q == WdTerm) begin
               rx_d    = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            rsp_valid_o[grant_q] = 1'b1;
            last_d               = grant_q;
            if (cfg_gap_i == 8'd0) begin
               state_d = StIdle;
            end else begin
               gap_d   = cfg_gap_i;
               state_d = StGap;
            end
         end
         StGap: begin
            gap_d = gap_q - 8'd1;
            if (gap_q == 8'd1) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         last_q  <= IdW'(NUM_REQ - 1);
         grant_q <= '0;
         tx_q    <= '0;
         cs_q    <= '0;
         rx_q    <= '0;
         err_q   <= 1'b0;
         gap_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         tx_q    <= tx_d;
         cs_q    <= cs_d;
         rx_q    <= rx_d;
         err_q   <= err_d;
         gap_q   <= gap_d;
         wdog_q  <= wdog_d;
      end
   end

   assign rsp_rx_o     = rx_q;
   assign rsp_err_o    = err_q;
   assign grant_id_o   = grant_q;
   assign spi_tx_o     = tx_q;
   assign spi_cs_sel_o = cs_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed self-checking bench for spi_xfer_arbiter (2 requesters, TIMEOUT = 16).

module tb_spi_xfer_arbiter;

   localparam int unsigned NumReq  = 2;
   localparam int unsigned DataW   = 32;
   localparam int unsigned CsW     = 2;
   localparam int unsigned Timeout = 16;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NumReq-1:0]        req_valid;
   logic [NumReq-1:0]        req_ready;
   logic [NumReq*CsW-1:0]    req_cs;
   logic [NumReq*DataW-1:0]  req_tx;
   logic [NumReq-1:0]        rsp_valid;
   logic [DataW-1:0]         rsp_rx;
   logic                     rsp_err;
   logic [0:0]               grant_id;
   logic                     busy;
   logic [7:0]               cfg_gap;
   logic                     spi_start;
   logic [DataW-1:0]         spi_tx;
   logic [CsW-1:0]           spi_cs_sel;
   logic                     spi_busy;
   logic                     spi_done;
   logic [DataW-1:0]         spi_rx;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic        multi_ready = 1'b0;

   spi_xfer_arbiter #(
      .NUM_REQ (NumReq),
      .DATA_W  (DataW),
      .CS_W    (CsW),
      .TIMEOUT (Timeout)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_cs_i     (req_cs),
      .req_tx_i     (req_tx),
      .rsp_valid_o  (rsp_valid),
      .rsp_rx_o     (rsp_rx),
      .rsp_err_o    (rsp_err),
      .grant_id_o   (grant_id),
      .busy_o       (busy),
      .cfg_gap_i    (cfg_gap),
      .spi_start_o  (spi_start),
      .spi_tx_o     (spi_tx),
      .spi_cs_sel_o (spi_cs_sel),
      .spi_busy_i   (spi_busy),
      .spi_done_i   (spi_done),
      .spi_rx_i     (spi_rx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (req_ready == 2'b11) multi_ready <= 1'b1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Advance to 2ns after the next rising edge; inputs are driven there, outputs read 1ns later.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      spi_done  = 1'b0;
      spi_busy  = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   // Wait (bounded) for a grant, run one transfer with done 'lat' cycles after start.
   task automatic run_xfer(input int g, input logic [31:0] tx, input logic [1:0] cs,
                           input logic [31:0] rx, input int lat);
      int n = 0;
      logic [1:0] oh;
      oh = 2'b01 << g;
      while (req_ready == '0 && n < 64) begin
         cyc();
         #1;
         n++;
      end
      check_eq("grant_ready", req_ready, oh);
      cyc();
      #1;
      check_eq("xfer_start", spi_start, 1'b1);
      check_eq("xfer_tx", spi_tx, tx);
      check_eq("xfer_cs", spi_cs_sel, cs);
      check_eq("xfer_grant_id", grant_id, g[0]);
      repeat (lat) cyc();
      spi_done = 1'b1;
      spi_rx   = rx;
      cyc();
      spi_done = 1'b0;
      #1;
      check_eq("xfer_rsp_valid", rsp_valid, oh);
      check_eq("xfer_rsp_rx", rsp_rx, rx);
      check_eq("xfer_rsp_err", rsp_err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_cs    = '0;
      req_tx    = '0;
      cfg_gap   = 8'd0;
      spi_busy  = 1'b0;
      spi_done  = 1'b0;
      spi_rx    = '0;
      repeat (2) cyc();
      #1;
      check_eq("rst_ready", req_ready, 2'b00);
      check_eq("rst_rsp_valid", rsp_valid, 2'b00);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_start", spi_start, 1'b0);
      check_eq("rst_tx", spi_tx, 32'h0);
      rst_n = 1'b1;

      // Single request, engine done 5 cycles after start.
      cyc();
      req_tx[31:0] = 32'hA5A5_0001;
      req_cs[1:0]  = 2'd2;
      req_valid    = 2'b01;
      #1;
      check_eq("t1_ready", req_ready, 2'b01);
      check_eq("t1_idle", busy, 1'b0);
      cyc();
      req_valid = 2'b00;
      #1;
      check_eq("t1_start", spi_start, 1'b1);
      check_eq("t1_cs", spi_cs_sel, 2'd2);
      check_eq("t1_tx", spi_tx, 32'hA5A5_0001);
      check_eq("t1_busy", busy, 1'b1);
      repeat (4) cyc();
      #1;
      check_eq("t1_start_once", spi_start, 1'b0);
      cyc();
      spi_done = 1'b1;
      spi_rx   = 32'h1234_5678;
      cyc();
      spi_done = 1'b0;
      #1;
      check_eq("t1_rsp_valid", rsp_valid, 2'b01);
      check_eq("t1_rsp_rx", rsp_rx, 32'h1234_5678);
      check_eq("t1_rsp_err", rsp_err, 1'b0);
      cyc();
      #1;
      check_eq("t1_rsp_once", rsp_valid, 2'b00);
      check_eq("t1_back_idle", busy, 1'b0);

      // Fairness: both requesters valid continuously, requester 0 first after reset.
      apply_reset();
      req_tx    = {32'hBBBB_0001, 32'hAAAA_0000};
      req_cs    = {2'd3, 2'd1};
      req_valid = 2'b11;
      #1;
      for (int i = 0; i < 6; i++) begin
         run_xfer(i % 2, (i % 2) ? 32'hBBBB_0001 : 32'hAAAA_0000, (i % 2) ? 2'd3 : 2'd1,
                  32'h1000_0000 + i, 2);
      end
      req_valid = 2'b00;
      check_eq("ready_onehot", multi_ready, 1'b0);

      // Gap of 3 cycles between back-to-back transfers.
      cyc();
      cfg_gap   = 8'd3;
      req_valid = 2'b01;
      #1;
      run_xfer(0, 32'hAAAA_0000, 2'd1, 32'h0000_0A01, 1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         #1;
         check_eq("gap_ready", req_ready, 2'b00);
         check_eq("gap_busy", busy, 1'b1);
      end
      cyc();
      #1;
      check_eq("gap_end_ready", req_ready, 2'b01);
      run_xfer(0, 32'hAAAA_0000, 2'd1, 32'h0000_0A02, 1);
      req_valid = 2'b00;
      repeat (3) cyc();
      cyc();
      #1;
      check_eq("gap_done_idle", busy, 1'b0);
      cfg_gap = 8'd0;

      // Engine busy for 4 cycles, then no done: watchdog abort after 16 WAIT cycles.
      spi_busy  = 1'b1;
      req_valid = 2'b10;
      #1;
      check_eq("to_ready", req_ready, 2'b10);
      for (int k = 0; k < 4; k++) begin
         cyc();
         req_valid = 2'b00;
         #1;
         check_eq("busy_hold_start", spi_start, 1'b0);
      end
      cyc();
      spi_busy = 1'b0;
      #1;
      check_eq("start_after_busy", spi_start, 1'b1);
      repeat (16) cyc();
      #1;
      check_eq("to_not_yet", rsp_valid, 2'b00);
      cyc();
      #1;
      check_eq("to_rsp_valid", rsp_valid, 2'b10);
      check_eq("to_rsp_err", rsp_err, 1'b1);
      check_eq("to_rsp_rx", rsp_rx, 32'h0);

      // Done on the terminal watchdog cycle wins.
      cyc();
      req_valid = 2'b10;
      #1;
      check_eq("term_ready", req_ready, 2'b10);
      cyc();
      req_valid = 2'b00;
      #1;
      check_eq("term_start", spi_start, 1'b1);
      repeat (16) cyc();
      spi_done = 1'b1;
      spi_rx   = 32'hCAFE_F00D;
      cyc();
      spi_done = 1'b0;
      #1;
      check_eq("term_rsp_valid", rsp_valid, 2'b10);
      check_eq("term_rsp_err", rsp_err, 1'b0);
      check_eq("term_rsp_rx", rsp_rx, 32'hCAFE_F00D);

      // Stray done while idle is ignored.
      cyc();
      spi_done = 1'b1;
      spi_rx   = 32'hDEAD_BEEF;
      cyc();
      spi_done = 1'b0;
      #1;
      check_eq("stray_rsp_valid", rsp_valid, 2'b00);
      check_eq("stray_busy", busy, 1'b0);
      check_eq("stray_rsp_rx", rsp_rx, 32'hCAFE_F00D);

      // Reset during WAIT drops the transfer.
      cyc();
      req_valid = 2'b01;
      #1;
      cyc();
      req_valid = 2'b00;
      #1;
      check_eq("mid_start", spi_start, 1'b1);
      repeat (3) cyc();
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_rsp_valid", rsp_valid, 2'b00);
      check_eq("mid_rst_rsp_rx", rsp_rx, 32'h0);
      check_eq("mid_rst_start", spi_start, 1'b0);
      check_eq("mid_rst_tx", spi_tx, 32'h0);
      check_eq("mid_rst_cs", spi_cs_sel, 2'd0);
      check_eq("mid_rst_grant_id", grant_id, 1'b0);
      spi_done = 1'b1;
      repeat (2) cyc();
      rst_n    = 1'b1;
      spi_done = 1'b0;
      cyc();
      #1;
      check_eq("post_rst_rsp_valid", rsp_valid, 2'b00);
      check_eq("post_rst_busy", busy, 1'b0);
      req_valid = 2'b10;
      #1;
      run_xfer(1, 32'hBBBB_0001, 2'd3, 32'h0000_0B01, 1);
      req_valid = 2'b11;
      cyc();
      #1;
      run_xfer(0, 32'hAAAA_0000, 2'd1, 32'h0000_0A03, 1);
      req_valid = 2'b00;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
